// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared SPI flash pins.
// Owner pins are passed through registered; a CS-high gap separates owners,
// and a watchdog reclaims a lock that is held with no traffic.
module spi_bus_arbiter #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic clk,
    input  logic IORST_n,
    input  logic req0,
    input  logic lock0,
    input  logic cs0_n,
    input  logic sclk0,
    input  logic mosi0,
    output logic gnt0,
    output logic miso0,
    input  logic req1,
    input  logic lock1,
    input  logic cs1_n,
    input  logic sclk1,
    input  logic mosi1,
    output logic gnt1,
    output logic miso1,
    output logic SPI_CLK,
    output logic SPI_CS_n,
    output logic SPI_MOSI,
    input  logic SPI_MISO,
    output logic busy,
    output logic timeout_err
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);
    localparam logic WdEnable = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StGap} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [15:0]     wd_q, wd_d;
    logic            terr_q, terr_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;

    // Owner's request-side signals, selected by the current owner state.
    logic own1;
    logic sel_req, sel_lock, sel_cs_n, sel_sclk, sel_mosi;
    logic idle_locked, rel_norm, rel_wd;

    assign own1     = (state_q == StOwn1);
    assign sel_req  = own1 ? req1  : req0;
    assign sel_lock = own1 ? lock1 : lock0;
    assign sel_cs_n = own1 ? cs1_n : cs0_n;
    assign sel_sclk = own1 ? sclk1 : sclk0;
    assign sel_mosi = own1 ? mosi1 : mosi0;

    assign idle_locked = !sel_req && sel_lock && sel_cs_n;
    assign rel_norm    = !sel_req && !sel_lock && sel_cs_n;
    assign rel_wd      = WdEnable && idle_locked && (wd_q == WdLast);

    // Next-state, pin pass-through, gap and watchdog counters.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gap_d   = gap_q;
        wd_d    = '0;
        terr_d  = 1'b0;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // last_q=1 means requester 1 released last, so 0 wins a tie.
                if (req0 && req1) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                cs_d   = sel_cs_n;
                sclk_d = sel_sclk;
                mosi_d = sel_mosi;
                if (idle_locked) begin
                    wd_d = wd_q + 16'd1;
                end
                if (rel_norm || rel_wd) begin
                    state_d = StGap;
                    last_d  = own1;
                    gap_d   = GapLast;
                    wd_d    = '0;
                    terr_d  = rel_wd;
                    cs_d    = 1'b1;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered pins; reset forces CS high and drops grants at once.
    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            gap_q   <= '0;
            wd_q    <= '0;
            terr_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            terr_q  <= terr_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign gnt0        = (state_q == StOwn0);
    assign gnt1        = own1;
    assign busy        = (state_q != StIdle);
    assign timeout_err = terr_q;
    assign SPI_CS_n    = cs_q;
    assign SPI_CLK     = sclk_q;
    assign SPI_MOSI    = mosi_q;
    assign miso0       = gnt0 & SPI_MISO;
    assign miso1       = gnt1 & SPI_MISO;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter (GAP_CYCLES=4, TIMEOUT=16).
module tb_spi_bus_arbiter;

    logic clk = 1'b0;
    logic IORST_n;
    logic req0, lock0, cs0_n, sclk0, mosi0, gnt0, miso0;
    logic req1, lock1, cs1_n, sclk1, mosi1, gnt1, miso1;
    logic SPI_CLK, SPI_CS_n, SPI_MOSI, SPI_MISO;
    logic busy, timeout_err;

    int checks = 0;
    int errors = 0;

    spi_bus_arbiter #(
        .GAP_CYCLES(4),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .IORST_n    (IORST_n),
        .req0       (req0),
        .lock0      (lock0),
        .cs0_n      (cs0_n),
        .sclk0      (sclk0),
        .mosi0      (mosi0),
        .gnt0       (gnt0),
        .miso0      (miso0),
        .req1       (req1),
        .lock1      (lock1),
        .cs1_n      (cs1_n),
        .sclk1      (sclk1),
        .mosi1      (mosi1),
        .gnt1       (gnt1),
        .miso1      (miso1),
        .SPI_CLK    (SPI_CLK),
        .SPI_CS_n   (SPI_CS_n),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_MISO   (SPI_MISO),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed hang expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic e_sclk, e_mosi, e_miso;
        IORST_n = 1'b0;
        req0 = 0; lock0 = 0; cs0_n = 1; sclk0 = 0; mosi0 = 0;
        req1 = 0; lock1 = 0; cs1_n = 1; sclk1 = 0; mosi1 = 0;
        SPI_MISO = 0;

        // Reset values.
        #12;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_cs", SPI_CS_n, 1);
        check("rst_clk", SPI_CLK, 0);
        check("rst_mosi", SPI_MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        @(negedge clk);
        IORST_n = 1'b1;
        tick();

        // Simultaneous request after reset: requester 0 wins.
        req0 = 1; req1 = 1;
        tick();
        check("tie_gnt0", gnt0, 1);
        check("tie_gnt1", gnt1, 0);
        check("tie_busy", busy, 1);
        check("entry_cs", SPI_CS_n, 1);

        // 40-clock frame by requester 0 while requester 1 toggles its pins.
        for (int i = 0; i < 40; i++) begin
            e_sclk = i[0];
            e_mosi = i[1] ^ i[2];
            e_miso = i[0] ^ i[2];
            cs0_n = 0; sclk0 = e_sclk; mosi0 = e_mosi;
            SPI_MISO = e_miso;
            cs1_n = i[0]; sclk1 = ~i[0]; mosi1 = i[1];
            #1;
            check("frame_miso0", miso0, e_miso);
            check("frame_miso1", miso1, 0);
            tick();
            check("frame_cs", SPI_CS_n, 0);
            check("frame_clk", SPI_CLK, e_sclk);
            check("frame_mosi", SPI_MOSI, e_mosi);
            check("frame_gnt1", gnt1, 0);
        end
        cs1_n = 1; sclk1 = 0; mosi1 = 0; SPI_MISO = 0;

        // Requester 0 releases; requester 1 waits out the gap.
        req0 = 0; cs0_n = 1; sclk0 = 0; mosi0 = 0;
        tick();
        check("rel0_gnt0", gnt0, 0);
        check("rel0_gnt1", gnt1, 0);
        check("rel0_cs", SPI_CS_n, 1);
        check("rel0_busy", busy, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("gap_busy", busy, 1);
            check("gap_gnt1", gnt1, 0);
            check("gap_cs", SPI_CS_n, 1);
        end
        tick();
        check("gap_end_busy", busy, 0);
        check("gap_end_gnt1", gnt1, 0);
        check("gap_end_cs", SPI_CS_n, 1);
        tick();
        check("gnt1_after_gap", gnt1, 1);
        check("gnt0_after_gap", gnt0, 0);

        // Requester 1 drops req1 mid-frame; ownership holds until CS rises.
        cs1_n = 0; sclk1 = 1; mosi1 = 1; SPI_MISO = 1;
        #1;
        check("own1_miso1", miso1, 1);
        check("own1_miso0", miso0, 0);
        tick();
        check("own1_cs", SPI_CS_n, 0);
        check("own1_clk", SPI_CLK, 1);
        check("own1_mosi", SPI_MOSI, 1);
        req1 = 0; sclk1 = 0; mosi1 = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_gnt1", gnt1, 1);
            check("hold_cs", SPI_CS_n, 0);
        end
        cs1_n = 1; SPI_MISO = 0;
        tick();
        check("rel1_gnt1", gnt1, 0);
        check("rel1_cs", SPI_CS_n, 1);
        check("rel1_terr", timeout_err, 0);
        for (int k = 0; k < 4; k++) tick();
        check("rel1_idle", busy, 0);

        // Abandoned lock: watchdog reclaims after 16 idle-locked clocks.
        req0 = 1; lock0 = 1;
        tick();
        check("wd_gnt0", gnt0, 1);
        req0 = 0; req1 = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("wd_hold_gnt0", gnt0, 1);
            check("wd_hold_terr", timeout_err, 0);
        end
        tick();
        check("wd_rel_gnt0", gnt0, 0);
        check("wd_rel_terr", timeout_err, 1);
        check("wd_rel_cs", SPI_CS_n, 1);
        tick();
        check("wd_pulse_end", timeout_err, 0);
        check("wd_gap_gnt1", gnt1, 0);
        for (int k = 0; k < 3; k++) tick();
        check("wd_gap_end_gnt1", gnt1, 0);
        tick();
        check("wd_gnt1", gnt1, 1);
        lock0 = 0; req1 = 0;
        tick();
        check("wd_rel1_gnt1", gnt1, 0);
        for (int k = 0; k < 4; k++) tick();
        check("wd_idle", busy, 0);

        // Reset mid-frame drops CS and grants asynchronously.
        req0 = 1;
        tick();
        check("mr_gnt0", gnt0, 1);
        cs0_n = 0;
        tick();
        check("mr_cs_low", SPI_CS_n, 0);
        #2;
        IORST_n = 1'b0;
        #1;
        check("mr_cs", SPI_CS_n, 1);
        check("mr_gnt0_drop", gnt0, 0);
        check("mr_gnt1_drop", gnt1, 0);
        check("mr_busy", busy, 0);
        cs0_n = 1; req1 = 1;
        @(negedge clk);
        IORST_n = 1'b1;
        tick();
        check("mr_tie_gnt0", gnt0, 1);
        check("mr_tie_gnt1", gnt1, 0);

        // Lone release, gap, back to idle with CS held high.
        req0 = 0; req1 = 0;
        tick();
        check("end_gnt0", gnt0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("end_gap_cs", SPI_CS_n, 1);
        end
        check("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Two-requester arbiter for the single SPI flash pin set (SPI_CLK/SPI_CS_n/SPI_MOSI/SPI_MISO).
- Requester 0 is the Zorro III ROM/port read engine. Requester 1 is the flash programming/status-poll sequencer.
- Grants the bus round-robin and enforces a minimum CS-high gap between owners.
- Supports bus lock across multiple CS frames (port HOLD accesses), with a watchdog that reclaims an abandoned lock.

Parameters:
- GAP_CYCLES, 4: clk cycles SPI_CS_n is held high between ownership changes. Must be >= 1.
- TIMEOUT, 4095: idle-locked cycles before forced release. 0 disables the watchdog. Counter is 16 bits wide.

Ports:
- clk  in  1  system clock
- IORST_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants the bus
- lock0  in  1  requester 0 keeps ownership between frames
- cs0_n  in  1  requester 0 chip select
- sclk0  in  1  requester 0 SPI clock
- mosi0  in  1  requester 0 data out
- gnt0  out  1  requester 0 owns the bus
- miso0  out  1  SPI_MISO forwarded to requester 0
- req1, lock1, cs1_n, sclk1, mosi1  in  1 each  same meanings for requester 1
- gnt1  out  1  requester 1 owns the bus
- miso1  out  1  SPI_MISO forwarded to requester 1
- SPI_CLK  out  1  flash clock
- SPI_CS_n  out  1  flash chip select
- SPI_MOSI  out  1  flash data in
- SPI_MISO  in  1  flash data out
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset is asynchronous and active-low (IORST_n); clock is clk.
- Reset values:
  - state=IDLE, gnt0=gnt1=0, SPI_CS_n=1, SPI_CLK=0, SPI_MOSI=0.
  - timeout_err=0, busy=0, gapcnt=0, wdcnt=0.
  - last_owner=1, so requester 0 wins the first simultaneous request.
- Reset mid-frame: SPI_CS_n goes high asynchronously and both grants drop. There is no completion of the in-flight frame.
- States: IDLE, OWN0, OWN1, GAP.
- IDLE:
  - req0 && req1 -> OWN(not last_owner).
  - Only req0 -> OWN0. Only req1 -> OWN1.
  - gnt_x rises on the same edge the state enters OWNx (req sampled at edge N, gnt high after edge N).
- OWNx:
  - Registered pin pass-through: SPI_CS_n<=cs_x_n, SPI_CLK<=sclk_x, SPI_MOSI<=mosi_x. Output latency is 1 clk.
  - Non-owner pins are ignored entirely.
  - Ownership holds while req_x || lock_x || !cs_x_n.
  - Release condition: !req_x && !lock_x && cs_x_n. On release: state<=GAP, gnt_x<=0, last_owner<=x, gapcnt<=GAP_CYCLES-1, SPI_CS_n<=1, SPI_CLK<=0, SPI_MOSI<=0.
  - Dropping req_x while cs_x_n=0 does not release; ownership holds until CS returns high.
  - No preemption: the other requester waits regardless of priority.
- Watchdog (OWNx):
  - wdcnt increments each cycle with !req_x && lock_x && cs_x_n.
  - wdcnt clears on any cycle with req_x || !cs_x_n, and on entry to OWNx.
  - When wdcnt==TIMEOUT-1 and TIMEOUT!=0: forced release exactly as normal release, plus timeout_err=1 for one cycle.
- GAP:
  - SPI_CS_n=1, SPI_CLK=0, SPI_MOSI=0, gnt0=gnt1=0.
  - gapcnt decrements; at 0 -> IDLE. Requests arriving during GAP are held until IDLE.
  - Total CS-high time between owners is >= GAP_CYCLES+1 clk.
- Fairness: the requester that just released loses a simultaneous tie on the next arbitration. A lone requester may re-acquire after the gap.
- MISO routing is combinational: miso_x = gnt_x & SPI_MISO. The non-owner always sees 0.
- Invariants:
  - gnt0 && gnt1 is never true.
  - SPI_CS_n is never low outside OWNx.
  - busy = (state != IDLE).

Test Plan:
- Reset released, req0 pulsed, requester 0 runs a 40-clock frame, then drops req0 with cs0_n=1 -> gnt0 high 1 clk after req, SPI pins mirror requester 0 delayed 1 clk, then CS high for 5 clk (GAP_CYCLES=4) and busy=0.
- req0 and req1 asserted on the same cycle after reset -> gnt0 first. After requester 0 releases with req1 still high, gnt1 rises exactly GAP_CYCLES+1 clk after gnt0 falls.
- Owner 1 drops req1 while cs1_n=0 for 3 more clk -> gnt1 stays high until cs1_n rises. Release occurs on the edge after cs1_n=1.
- lock0=1, req0=0, cs0_n=1 held with TIMEOUT=16 -> forced release after 16 idle-locked clk, timeout_err high exactly 1 clk, gnt0=0. A pending req1 is granted after the gap.
- IORST_n asserted mid-frame while SPI_CS_n=0 -> SPI_CS_n=1 and gnt0=gnt1=0 immediately (async). After release, state is IDLE and the next simultaneous request goes to requester 0.
- Requester 1 toggles cs1_n/sclk1 while requester 0 owns -> SPI pins and miso1 are unaffected (miso1=0 throughout).
